ex_stage: RTL

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage_pkg.sv | 123 ++++++++++++
 rtl/ex_stage_serial_shifter.sv | 55 +++++
 rtl/ex_stage.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_pkg
// Description : Shared definitions for the execute stage: operation codes
//               (EXE_*_OP), result classes (EXE_RES_*), bus widths, write
//               enable constants, FSM state type and the combinational ALU
//               helpers used by ex_stage and serial_shifter.
// Config      : SERIAL_SHIFT_EN (consumed by ex_stage, not by this package)
// Revision    : 1.0 - initial release
// ============================================================================
package ex_stage_pkg;

  // Bus widths (RegBus, RegAddrBus, AluOpBus, AluSelBus)
  localparam int REG_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int ALU_OP_WIDTH   = 8;
  localparam int ALU_SEL_WIDTH  = 3;

  localparam logic [REG_WIDTH-1:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic                 WRITE_ENABLE  = 1'b1;
  localparam logic                 WRITE_DISABLE = 1'b0;

  // Operation codes
  localparam logic [ALU_OP_WIDTH-1:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_LUI_OP  = 8'b0000_1111;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_ADD_OP  = 8'b0010_0000;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_SUB_OP  = 8'b0010_0010;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_SLTU_OP = 8'b0010_1011;

  // Result classes
  localparam logic [ALU_SEL_WIDTH-1:0] EXE_RES_NOP        = 3'b000;
  localparam logic [ALU_SEL_WIDTH-1:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [ALU_SEL_WIDTH-1:0] EXE_RES_SHIFT      = 3'b010;
  localparam logic [ALU_SEL_WIDTH-1:0] EXE_RES_ARITHMETIC = 3'b100;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_mode_t;

  // Result class each opcode belongs to; unknown opcodes map to NOP.
  function automatic logic [ALU_SEL_WIDTH-1:0] expected_sel(
    input logic [ALU_OP_WIDTH-1:0] op
  );
    logic [ALU_SEL_WIDTH-1:0] sel;
    sel = EXE_RES_NOP;
    case (op)
      EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_LUI_OP: sel = EXE_RES_LOGIC;
      EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP:            sel = EXE_RES_SHIFT;
      EXE_ADD_OP, EXE_SUB_OP, EXE_SLT_OP, EXE_SLTU_OP: sel = EXE_RES_ARITHMETIC;
      default:                                       sel = EXE_RES_NOP;
    endcase
    return sel;
  endfunction

  // Unqualified single-cycle result (shifts are full barrel shifts here).
  function automatic logic [REG_WIDTH-1:0] alu_raw(
    input logic [ALU_OP_WIDTH-1:0] op,
    input logic [REG_WIDTH-1:0]    a,
    input logic [REG_WIDTH-1:0]    b
  );
    logic [REG_WIDTH-1:0] r;
    r = ZERO_WORD;
    case (op)
      EXE_AND_OP:  r = a & b;
      EXE_OR_OP:   r = a | b;
      EXE_XOR_OP:  r = a ^ b;
      EXE_LUI_OP:  r = b;
      EXE_ADD_OP:  r = a + b;
      EXE_SUB_OP:  r = a - b;
      EXE_SLT_OP:  r = {31'd0, ($signed(a) < $signed(b))};
      EXE_SLTU_OP: r = {31'd0, (a < b)};
      EXE_SLL_OP:  r = a << b[4:0];
      EXE_SRL_OP:  r = a >> b[4:0];
      EXE_SRA_OP:  r = $unsigned($signed(a) >>> b[4:0]);
      default:     r = ZERO_WORD;
    endcase
    return r;
  endfunction

  function automatic logic is_shift_op(input logic [ALU_OP_WIDTH-1:0] op);
    return (op == EXE_SLL_OP) || (op == EXE_SRL_OP) || (op == EXE_SRA_OP);
  endfunction

  function automatic shift_mode_t shift_mode_of(input logic [ALU_OP_WIDTH-1:0] op);
    shift_mode_t m;
    m = SH_SLL;
    if (op == EXE_SRL_OP) m = SH_SRL;
    else if (op == EXE_SRA_OP) m = SH_SRA;
    return m;
  endfunction

  // One-bit step of the serial shifter.
  function automatic logic [REG_WIDTH-1:0] shift_one(
    input logic [REG_WIDTH-1:0] v,
    input shift_mode_t          m
  );
    logic [REG_WIDTH-1:0] r;
    r = v;
    case (m)
      SH_SLL:  r = {v[REG_WIDTH-2:0], 1'b0};
      SH_SRL:  r = {1'b0, v[REG_WIDTH-1:1]};
      SH_SRA:  r = {v[REG_WIDTH-1], v[REG_WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_serial_shifter.sv
`default_nettype none
// ============================================================================
// Module      : serial_shifter
// Description : One-bit-per-cycle shifter for SLL/SRL/SRA. The first bit is
//               shifted on the load edge, so after a load with shamt=N the
//               result is final once busy drops, N-1 cycles later.
//               A load with shamt=0 is not meaningful; the caller completes
//               zero-distance shifts itself.
// Ports       : clk, rst (async active-low)
//               load  in  - start a new shift
//               value in  - operand to shift
//               shamt in  - shift distance (1..31)
//               mode  in  - SH_SLL / SH_SRL / SH_SRA
//               busy  out - shift still in progress
//               result out- shifted value (valid when busy is 0)
// Config      : instantiated by ex_stage only when SERIAL_SHIFT_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
module serial_shifter
  import ex_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [REG_WIDTH-1:0] value,
  input  logic [4:0]           shamt,
  input  shift_mode_t          mode,
  output logic                 busy,
  output logic [REG_WIDTH-1:0] result
);

  logic [REG_WIDTH-1:0] data;
  logic [4:0]           count;
  shift_mode_t          mode_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data   <= ZERO_WORD;
      count  <= 5'd0;
      mode_q <= SH_SLL;
    end else if (load) begin
      data   <= shift_one(value, mode);
      count  <= shamt - 5'd1;
      mode_q <= mode;
    end else if (count != 5'd0) begin
      data  <= shift_one(data, mode_q);
      count <= count - 5'd1;
    end
  end

  assign busy   = (count != 5'd0);
  assign result = data;

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : Execute stage. Computes logic/arithmetic/shift results for
//               the op accepted from decode and registers them for the
//               memory stage, with forwarding taps back to decode.
// Ports       : clk, rst (async active-low)
//               in_valid_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i
//                 - decoded op from decode
//               in_ready_o / stall_req_o - accept handshake / stall request
//               wdata_o, wd_o, wreg_o, out_valid_o - registered result
//               ex_wreg_o, ex_wd_o, ex_wdata_o - forwarding taps
// Config      : SERIAL_SHIFT_EN - when defined, SLL/SRL/SRA with a nonzero
//               distance use the serial shifter (IDLE -> SHIFT, latency
//               shamt+1). When undefined all ops are single cycle and
//               in_ready_o is constantly 1.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid_i,
  input  logic [ALU_OP_WIDTH-1:0]   aluop_i,
  input  logic [ALU_SEL_WIDTH-1:0]  alusel_i,
  input  logic [REG_WIDTH-1:0]      reg1_i,
  input  logic [REG_WIDTH-1:0]      reg2_i,
  input  logic [REG_ADDR_WIDTH-1:0] wd_i,
  input  logic                      wreg_i,
  output logic                      in_ready_o,
  output logic                      stall_req_o,
  output logic [REG_WIDTH-1:0]      wdata_o,
  output logic [REG_ADDR_WIDTH-1:0] wd_o,
  output logic                      wreg_o,
  output logic                      out_valid_o,
  output logic                      ex_wreg_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_wd_o,
  output logic [REG_WIDTH-1:0]      ex_wdata_o
);

  logic                      accept;
  logic [REG_WIDTH-1:0]      alu_result;
  logic                      load_out;
  logic [REG_WIDTH-1:0]      next_wdata;
  logic [REG_ADDR_WIDTH-1:0] next_wd;
  logic                      next_wreg;

  // A class mismatch between aluop and alusel squashes the result to zero.
  assign alu_result = (alusel_i == expected_sel(aluop_i))
                    ? alu_raw(aluop_i, reg1_i, reg2_i)
                    : ZERO_WORD;

  assign accept = in_valid_i && in_ready_o;

`ifdef SERIAL_SHIFT_EN
  state_t                    state;
  state_t                    state_next;
  logic                      serial_start;
  logic                      shift_busy;
  logic [REG_WIDTH-1:0]      shift_result;
  shift_mode_t               shift_mode;
  logic [REG_ADDR_WIDTH-1:0] pend_wd;
  logic                      pend_wreg;

  // Ready depends on state only, so the accept path has no combinational loop.
  assign in_ready_o = (state == ST_IDLE);

  // Zero-distance and class-mismatched shifts complete in one cycle.
  assign serial_start = accept && is_shift_op(aluop_i)
                     && (alusel_i == EXE_RES_SHIFT)
                     && (reg2_i[4:0] != 5'd0);

  assign shift_mode = shift_mode_of(aluop_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Destination of the in-flight serial op; decode moves on after accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_wd   <= '0;
      pend_wreg <= WRITE_DISABLE;
    end else if (serial_start) begin
      pend_wd   <= wd_i;
      pend_wreg <= wreg_i;
    end
  end

  always_comb begin
    state_next = state;
    load_out   = 1'b0;
    next_wdata = alu_result;
    next_wd    = wd_i;
    next_wreg  = wreg_i;
    case (state)
      ST_IDLE: begin
        if (serial_start) begin
          state_next = ST_SHIFT;
        end else begin
          load_out = accept;
        end
      end
      ST_SHIFT: begin
        if (!shift_busy) begin
          state_next = ST_IDLE;
          load_out   = 1'b1;
          next_wdata = shift_result;
          next_wd    = pend_wd;
          next_wreg  = pend_wreg;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  serial_shifter u_serial_shifter (
    .clk    (clk),
    .rst    (rst),
    .load   (serial_start),
    .value  (reg1_i),
    .shamt  (reg2_i[4:0]),
    .mode   (shift_mode),
    .busy   (shift_busy),
    .result (shift_result)
  );
`else
  assign in_ready_o = 1'b1;

  always_comb begin
    load_out   = accept;
    next_wdata = alu_result;
    next_wd    = wd_i;
    next_wreg  = wreg_i;
  end
`endif

  // Output register: payload holds when nothing completes; valid is a pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_o <= 1'b0;
      wdata_o     <= ZERO_WORD;
      wd_o        <= '0;
      wreg_o      <= WRITE_DISABLE;
    end else begin
      out_valid_o <= load_out;
      if (load_out) begin
        wdata_o <= next_wdata;
        wd_o    <= next_wd;
        wreg_o  <= next_wreg;
      end
    end
  end

  assign stall_req_o = !in_ready_o;

  // Forward only a completed result; stale payload is never offered.
  assign ex_wreg_o  = wreg_o && out_valid_o;
  assign ex_wd_o    = wd_o;
  assign ex_wdata_o = wdata_o;

endmodule
`default_nettype wire
